// File: rtl/cpu_pkg.sv
// Shared CPU definitions: base opcodes, hazard shadow-pipe entry and forward select encodings.
package cpu_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FLW    = 7'b0000111;
  localparam logic [6:0] FSW    = 7'b0100111;
  localparam logic [6:0] FALU   = 7'b1010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef struct packed {
    logic       valid;
    logic [5:0] rd;
    logic       is_load;
  } hz_entry_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  function automatic logic rs1_used(input logic [6:0] op);
    return !(op == LUI || op == AUIPC || op == JAL);
  endfunction

  function automatic logic rs2_used(input logic [6:0] op);
    return (op == OP_REG) || (op == STORE) || (op == BRANCH) || (op == FSW) || (op == FALU);
  endfunction

  function automatic logic op_is_load(input logic [6:0] op);
    return (op == LOAD) || (op == FLW);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard interface: pipeline side (master) drives instruction fields, hazard_ctrl (slave) answers.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  logic [1:0] busStall;
  logic [6:0] opcode;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [5:0] rd_addr;
  logic       branch_taken_EX;
  logic       reg1_sel;
  logic       reg2_sel;
  logic [1:0] fwd1_EX;
  logic [1:0] fwd2_EX;
  logic       stall_IF_ID;
  logic       bubble_ID_EXE;
  logic       flush_IF_ID;

  modport master (
    output busStall, opcode, rs1_addr, rs2_addr, rd_addr, branch_taken_EX,
    input  reg1_sel, reg2_sel, fwd1_EX, fwd2_EX, stall_IF_ID, bubble_ID_EXE, flush_IF_ID
  );

  modport slave (
    input  busStall, opcode, rs1_addr, rs2_addr, rd_addr, branch_taken_EX,
    output reg1_sel, reg2_sel, fwd1_EX, fwd2_EX, stall_IF_ID, bubble_ID_EXE, flush_IF_ID
  );

endinterface

// File: rtl/hz_match.sv
// Tag compare of one ID source against one shadow-pipe entry; x0 never hazards, f0 does.
module hz_match
  import cpu_pkg::*;
(
  input  logic [5:0] src,
  input  logic       used,
  input  hz_entry_t  entry,
  output logic       hit
);

  assign hit = used && entry.valid && (entry.rd != 6'd0) && (src == entry.rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadow pipe of in-flight destinations driving bypass,
// forward, load-use stall and branch flush controls.
module hazard_ctrl
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  hz_entry_t ex_q, mem_q, wb_q;
  fwd_sel_e  fwd1_q, fwd2_q;
  fwd_sel_e  fwd1_d, fwd2_d;

  logic [5:0] src1, src2;
  logic       use1, use2;
  logic       h1_ex, h1_mem, h1_wb;
  logic       h2_ex, h2_mem, h2_wb;
  logic       freeze, load_use, bubble;
  logic       fetch_stall_unused;

  assign fetch_stall_unused = hz.busStall[0];
  assign freeze = hz.busStall[1];

  assign src1 = {hz.opcode == FALU, hz.rs1_addr};
  assign src2 = {(hz.opcode == FALU) || (hz.opcode == FSW), hz.rs2_addr};
  assign use1 = rs1_used(hz.opcode);
  assign use2 = rs2_used(hz.opcode);

  hz_match u_m1_ex  (.src(src1), .used(use1), .entry(ex_q),  .hit(h1_ex));
  hz_match u_m1_mem (.src(src1), .used(use1), .entry(mem_q), .hit(h1_mem));
  hz_match u_m1_wb  (.src(src1), .used(use1), .entry(wb_q),  .hit(h1_wb));
  hz_match u_m2_ex  (.src(src2), .used(use2), .entry(ex_q),  .hit(h2_ex));
  hz_match u_m2_mem (.src(src2), .used(use2), .entry(mem_q), .hit(h2_mem));
  hz_match u_m2_wb  (.src(src2), .used(use2), .entry(wb_q),  .hit(h2_wb));

  // A taken branch kills the consumer anyway, so it suppresses the load-use stall.
  assign load_use = (h1_ex || h2_ex) && ex_q.is_load && !hz.branch_taken_EX;
  assign bubble   = (load_use || hz.branch_taken_EX) && !freeze;

  always_comb begin
    fwd1_d = FWD_NONE;
    if (h1_ex)       fwd1_d = FWD_MEM;
    else if (h1_mem) fwd1_d = FWD_WB;
  end

  always_comb begin
    fwd2_d = FWD_NONE;
    if (h2_ex)       fwd2_d = FWD_MEM;
    else if (h2_mem) fwd2_d = FWD_WB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      fwd1_q <= FWD_NONE;
      fwd2_q <= FWD_NONE;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q   <= '0;
        fwd1_q <= FWD_NONE;
        fwd2_q <= FWD_NONE;
      end else begin
        ex_q   <= '{valid: 1'b1, rd: hz.rd_addr, is_load: op_is_load(hz.opcode)};
        fwd1_q <= fwd1_d;
        fwd2_q <= fwd2_d;
      end
    end
  end

  // Outputs are forced low while reset is asserted so the effect is immediate.
  assign hz.reg1_sel      = h1_wb && !rst;
  assign hz.reg2_sel      = h2_wb && !rst;
  assign hz.fwd1_EX       = fwd1_q;
  assign hz.fwd2_EX       = fwd2_q;
  assign hz.stall_IF_ID   = load_use && !freeze && !rst;
  assign hz.bubble_ID_EXE = bubble && !rst;
  assign hz.flush_IF_ID   = hz.branch_taken_EX && !rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand sequences for bus stall and reset.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  typedef struct {
    logic [1:0] bs;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [5:0] rd;
    logic       br;
    logic [8:0] exp;  // {reg1_sel, reg2_sel, stall, bubble, flush, fwd1[1:0], fwd2[1:0]}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));

  int total = 0;
  int bad   = 0;
  logic [8:0] sb_q[$];
  vec_t tbl[27];
  vec_t seq[12];

  function automatic vec_t mk(input logic [1:0] bs, input logic [6:0] op, input int rs1,
                              input int rs2, input int rd, input logic br, input logic [8:0] e);
    vec_t v;
    v.bs = bs; v.op = op; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 6'(rd); v.br = br; v.exp = e;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {hz.reg1_sel, hz.reg2_sel, hz.stall_IF_ID, hz.bubble_ID_EXE, hz.flush_IF_ID,
            hz.fwd1_EX, hz.fwd2_EX};
  endfunction

  task automatic drive(input vec_t v);
    hz.busStall = v.bs; hz.opcode = v.op; hz.rs1_addr = v.rs1; hz.rs2_addr = v.rs2;
    hz.rd_addr = v.rd; hz.branch_taken_EX = v.br;
    sb_q.push_back(v.exp);
  endtask

  task automatic check(input string tag);
    logic [8:0] e;
    logic [8:0] a;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", tag, outs());
    end else begin
      e = sb_q.pop_front();
      a = outs();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got r1 r2 st bb fl f1 f2 = %b want %b", tag, a, e);
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Plain instructions, forwarding, load-use and FP tag cases.
    tbl[0]  = mk(2'b00, OP_REG, 1, 2, 5,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[1]  = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[2]  = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[3]  = mk(2'b00, OP_REG, 5, 6, 8,  1'b0, 9'b1_0_0_0_0_00_00);
    tbl[4]  = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[5]  = mk(2'b00, OP_REG, 0, 0, 7,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[6]  = mk(2'b00, OP_REG, 1, 7, 9,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[7]  = mk(2'b00, OP_REG, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_01);
    tbl[8]  = mk(2'b00, OP_REG, 0, 3, 4,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[9]  = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[10] = mk(2'b00, LOAD,   1, 0, 3,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[11] = mk(2'b00, OP_REG, 3, 0, 10, 1'b0, 9'b0_0_1_1_0_00_00);
    tbl[12] = mk(2'b00, OP_REG, 3, 0, 10, 1'b0, 9'b0_0_0_0_0_00_00);
    tbl[13] = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_10_00);
    tbl[14] = mk(2'b00, LOAD,   1, 0, 3,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[15] = mk(2'b00, OP_REG, 3, 0, 10, 1'b1, 9'b0_0_0_1_1_00_00);
    tbl[16] = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[17] = mk(2'b00, FLW,    1, 0, 34, 1'b0, 9'b0_0_0_0_0_00_00);
    tbl[18] = mk(2'b00, FALU,   0, 2, 35, 1'b0, 9'b0_0_1_1_0_00_00);
    tbl[19] = mk(2'b00, FLW,    1, 0, 34, 1'b0, 9'b0_0_0_0_0_00_00);
    tbl[20] = mk(2'b00, OP_REG, 0, 2, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[21] = mk(2'b00, FLW,    1, 0, 34, 1'b0, 9'b0_0_0_0_0_00_00);
    tbl[22] = mk(2'b00, FSW,    1, 2, 0,  1'b0, 9'b0_1_1_1_0_00_00);
    tbl[23] = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_00);
    tbl[24] = mk(2'b00, FALU,   1, 1, 32, 1'b0, 9'b0_0_0_0_0_00_00);
    tbl[25] = mk(2'b00, FALU,   0, 5, 36, 1'b0, 9'b0_0_0_0_0_00_00);
    tbl[26] = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_01_00);

    // Bus stall held across a pending load-use, then reset mid-hold.
    seq[0]  = mk(2'b00, OP_REG, 1, 1, 6,  1'b0, 9'b0_0_0_0_0_00_00);
    seq[1]  = mk(2'b00, LOAD,   6, 0, 3,  1'b0, 9'b0_0_0_0_0_00_00);
    seq[2]  = mk(2'b10, OP_REG, 0, 3, 11, 1'b0, 9'b0_0_0_0_0_01_00);
    seq[3]  = mk(2'b10, OP_REG, 0, 3, 11, 1'b0, 9'b0_0_0_0_0_01_00);
    seq[4]  = mk(2'b10, OP_REG, 0, 3, 11, 1'b0, 9'b0_0_0_0_0_01_00);
    seq[5]  = mk(2'b00, OP_REG, 0, 3, 11, 1'b0, 9'b0_0_1_1_0_01_00);
    seq[6]  = mk(2'b00, OP_REG, 0, 3, 11, 1'b0, 9'b0_0_0_0_0_00_00);
    seq[7]  = mk(2'b00, OP_IMM, 0, 0, 0,  1'b0, 9'b0_0_0_0_0_00_10);
    seq[8]  = mk(2'b00, LOAD,   11, 0, 3, 1'b0, 9'b0_0_0_0_0_00_00);
    seq[9]  = mk(2'b10, OP_REG, 3, 0, 13, 1'b0, 9'b0_0_0_0_0_10_00);
    seq[10] = mk(2'b10, OP_REG, 3, 0, 13, 1'b1, 9'b0_0_0_0_1_10_00);
    seq[11] = mk(2'b00, OP_REG, 3, 0, 13, 1'b0, 9'b0_0_0_0_0_00_00);

    rst = 1'b1;
    drive(mk(2'b00, OP_IMM, 0, 0, 0, 1'b0, 9'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 11; i++) step(seq[i], $sformatf("seq%0d", i));

    // Asynchronous reset while the bus stall holds a pending load-use and a branch is asserted.
    rst = 1'b1;
    sb_q.push_back(9'b0);
    #1;
    check("async_reset");
    #2;
    rst = 1'b0;
    step(seq[11], "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
